// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Shares one command-word RAM port between an SPI slave and a local host.
// Every RAM access is a sequence of 10-bit command words {cmd[1:0], payload}:
//   00 write address, 01 write data, 10 read address, 11 read data.
// SPI always has priority. An SPI word is forwarded directly when the SPI
// side may use the RAM port. Otherwise it is parked in a one-entry buffer,
// and a word that finds that buffer full is dropped. A host access is
// granted only when no SPI word is pending. The host path issues the
// address and data words on consecutive cycles. For a host read it then
// waits, bounded by TIMEOUT_CYC, for the RAM to return data.
//
// Ports
//   clk           in   single clock, rising edge
//   rst_n         in   synchronous active-low reset
//   spi_rx_data   in   [9:8] cmd, [7:0] payload from SPI slave
//   spi_rx_valid  in   one-cycle strobe for spi_rx_data
//   spi_tx_data   out  RAM read data towards SPI slave
//   spi_tx_valid  out  strobe for spi_tx_data (held low while host reads)
//   host_req      in   host requests one RAM access
//   host_we       in   1 = write, 0 = read
//   host_addr     in   host address
//   host_wdata    in   host write data
//   host_gnt      out  one-cycle accept pulse (request latched that edge)
//   host_rdata    out  host read data
//   host_rvalid   out  one-cycle strobe for host_rdata
//   ram_din       out  command word to RAM
//   ram_rx_valid  out  strobe for ram_din
//   ram_dout      in   RAM read data
//   ram_tx_valid  in   strobe for ram_dout
//   err           out  sticky: [0] SPI word dropped, [1] host read timeout
// ---------------------------------------------------------------------------
module ram_arbiter #(
   parameter int TIMEOUT_CYC = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] spi_rx_data,
   input  logic       spi_rx_valid,
   output logic [7:0] spi_tx_data,
   output logic       spi_tx_valid,
   input  logic       host_req,
   input  logic       host_we,
   input  logic [7:0] host_addr,
   input  logic [7:0] host_wdata,
   output logic       host_gnt,
   output logic [7:0] host_rdata,
   output logic       host_rvalid,
   output logic [9:0] ram_din,
   output logic       ram_rx_valid,
   input  logic [7:0] ram_dout,
   input  logic       ram_tx_valid,
   output logic [1:0] err
);

   typedef enum logic [2:0] {
      IDLE,
      SPI_OWN,
      H_ADDR,
      H_DATA,
      H_WAIT
   } state_t;

   localparam logic [1:0] CMD_WADDR = 2'b00;
   localparam logic [1:0] CMD_WDATA = 2'b01;
   localparam logic [1:0] CMD_RADDR = 2'b10;
   localparam logic [1:0] CMD_RDATA = 2'b11;

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state;
   logic             buf_valid;
   logic [9:0]       buf_data;
   logic             rd_pend;     // SPI_OWN: a cmd 11 went out, awaiting RAM data
   logic [CNT_W-1:0] tmo_cnt;
   logic             h_we;
   logic [7:0]       h_addr;
   logic [7:0]       h_wdata;

   // SPI may drive the RAM port only while no host transaction is underway.
   logic       spi_slot;
   logic       fwd;
   logic [9:0] fwd_word;
   logic [1:0] fwd_cmd;

   assign spi_slot = (state == IDLE) || (state == SPI_OWN);
   assign fwd      = spi_slot && (buf_valid || spi_rx_valid);
   // The buffered word is older, so it always goes out first.
   assign fwd_word = buf_valid ? buf_data : spi_rx_data;
   assign fwd_cmd  = fwd_word[9:8];

   // Read data is routed to SPI unless the host owns the outstanding read.
   assign spi_tx_data  = ram_dout;
   assign spi_tx_valid = ram_tx_valid && (state != H_WAIT);

   // NOTE: all state below is updated with non-blocking assignments, so every
   // branch reads the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         // NOTE: the one-entry buffer is a plain register pair, so both the
         // flag and the data are cleared to keep reset state fully defined.
         buf_valid    <= 1'b0;
         buf_data     <= '0;
         rd_pend      <= 1'b0;
         tmo_cnt      <= '0;
         h_we         <= 1'b0;
         h_addr       <= '0;
         h_wdata      <= '0;
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
         host_gnt     <= 1'b0;
         host_rdata   <= '0;
         host_rvalid  <= 1'b0;
         err          <= '0;
      end else begin
         // Strobes default low; ram_din and host_rdata hold their last value.
         ram_rx_valid <= 1'b0;
         host_gnt     <= 1'b0;
         host_rvalid  <= 1'b0;

         // ---------------- SPI buffer ----------------
         if (fwd) begin
            if (buf_valid) begin
               // Buffer drains this cycle; a simultaneous arrival refills it.
               buf_valid <= spi_rx_valid;
               if (spi_rx_valid) begin
                  buf_data <= spi_rx_data;
               end
            end
         end else if (spi_rx_valid) begin
            if (!buf_valid) begin
               buf_valid <= 1'b1;
               buf_data  <= spi_rx_data;
            end else begin
               err[0] <= 1'b1;
            end
         end

         if (fwd) begin
            ram_din      <= fwd_word;
            ram_rx_valid <= 1'b1;
         end

         // ---------------- arbitration FSM ----------------
         case (state)
            IDLE: begin
               if (fwd) begin
                  // Address words open an SPI transaction; data words pass through.
                  if (fwd_cmd == CMD_WADDR || fwd_cmd == CMD_RADDR) begin
                     state   <= SPI_OWN;
                     rd_pend <= 1'b0;
                  end
               end else if (host_req) begin
                  host_gnt <= 1'b1;
                  h_we     <= host_we;
                  h_addr   <= host_addr;
                  h_wdata  <= host_wdata;
                  state    <= H_ADDR;
               end
            end

            SPI_OWN: begin
               if (fwd) begin
                  case (fwd_cmd)
                     CMD_WDATA: begin
                        state   <= IDLE;
                        rd_pend <= 1'b0;
                     end
                     CMD_RDATA: rd_pend <= 1'b1;
                     default:   rd_pend <= 1'b0;
                  endcase
               end else if (rd_pend && ram_tx_valid) begin
                  state   <= IDLE;
                  rd_pend <= 1'b0;
               end
            end

            H_ADDR: begin
               ram_din      <= {(h_we ? CMD_WADDR : CMD_RADDR), h_addr};
               ram_rx_valid <= 1'b1;
               state        <= H_DATA;
            end

            H_DATA: begin
               ram_rx_valid <= 1'b1;
               if (h_we) begin
                  ram_din <= {CMD_WDATA, h_wdata};
                  state   <= IDLE;
               end else begin
                  ram_din <= {CMD_RDATA, 8'h00};
                  tmo_cnt <= '0;
                  state   <= H_WAIT;
               end
            end

            H_WAIT: begin
               if (ram_tx_valid) begin
                  host_rdata  <= ram_dout;
                  host_rvalid <= 1'b1;
                  state       <= IDLE;
               end else if (tmo_cnt == CNT_LAST) begin
                  err[1] <= 1'b1;
                  state  <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Directed bench for ram_arbiter. A table of per-cycle records holds the
// stimulus and the outputs expected just after the following rising edge.
// It covers the SPI write, host write/read, priority, buffering/drop and
// pass-through cases. Hand-written sequences follow for the host read
// timeout and for reset during an in-flight host access.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] spi_rx_data;
   logic       spi_rx_valid;
   logic [7:0] spi_tx_data;
   logic       spi_tx_valid;
   logic       host_req;
   logic       host_we;
   logic [7:0] host_addr;
   logic [7:0] host_wdata;
   logic       host_gnt;
   logic [7:0] host_rdata;
   logic       host_rvalid;
   logic [9:0] ram_din;
   logic       ram_rx_valid;
   logic [7:0] ram_dout;
   logic       ram_tx_valid;
   logic [1:0] err;

   int tests = 0;
   int fails = 0;

   ram_arbiter #(.TIMEOUT_CYC(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi_rx_data  (spi_rx_data),
      .spi_rx_valid (spi_rx_valid),
      .spi_tx_data  (spi_tx_data),
      .spi_tx_valid (spi_tx_valid),
      .host_req     (host_req),
      .host_we      (host_we),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_gnt     (host_gnt),
      .host_rdata   (host_rdata),
      .host_rvalid  (host_rvalid),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_dout     (ram_dout),
      .ram_tx_valid (ram_tx_valid),
      .err          (err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       rst;
      logic       sv;
      logic [9:0] sd;
      logic       hr;
      logic       hw;
      logic [7:0] ha;
      logic [7:0] hd;
      logic       tv;
      logic [7:0] dq;
      logic       e_rv;
      logic [9:0] e_din;
      logic       e_gnt;
      logic       e_rvld;
      logic [7:0] e_rdata;
      logic [1:0] e_err;
      logic       e_stxv;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic rst, input logic sv, input logic [9:0] sd,
      input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd,
      input logic tv, input logic [7:0] dq,
      input logic e_rv, input logic [9:0] e_din, input logic e_gnt,
      input logic e_rvld, input logic [7:0] e_rdata, input logic [1:0] e_err,
      input logic e_stxv);
      vec_t v;
      v.rst = rst; v.sv = sv; v.sd = sd; v.hr = hr; v.hw = hw; v.ha = ha;
      v.hd = hd; v.tv = tv; v.dq = dq; v.e_rv = e_rv; v.e_din = e_din;
      v.e_gnt = e_gnt; v.e_rvld = e_rvld; v.e_rdata = e_rdata;
      v.e_err = e_err; v.e_stxv = e_stxv;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic sv, input logic [9:0] sd,
                        input logic hr, input logic hw, input logic [7:0] ha,
                        input logic [7:0] hd, input logic tv, input logic [7:0] dq);
      rst_n        = rst;
      spi_rx_valid = sv;
      spi_rx_data  = sd;
      host_req     = hr;
      host_we      = hw;
      host_addr    = ha;
      host_wdata   = hd;
      ram_tx_valid = tv;
      ram_dout     = dq;
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
   endtask

   initial begin
      // rst sv sd     hr hw ha     hd     tv dq    | rv din    gnt rvld rdata err   stxv
      vecs.push_back(mk(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 0, 0, 8'h00, 2'b00, 0)); // 0 reset
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h000, 0, 0, 8'h00, 2'b00, 0)); // 1 idle
      vecs.push_back(mk(1, 1, 10'h005, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h005, 0, 0, 8'h00, 2'b00, 0)); // 2 spi waddr
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h005, 0, 0, 8'h00, 2'b00, 0)); // 3
      vecs.push_back(mk(1, 1, 10'h1AB, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h1AB, 0, 0, 8'h00, 2'b00, 0)); // 4 spi wdata
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h1AB, 0, 0, 8'h00, 2'b00, 0)); // 5
      vecs.push_back(mk(1, 0, 10'h000, 1, 1, 8'h10, 8'h5A, 0, 8'h00, 0, 10'h1AB, 1, 0, 8'h00, 2'b00, 0)); // 6 host write gnt
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h010, 0, 0, 8'h00, 2'b00, 0)); // 7 addr word
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h15A, 0, 0, 8'h00, 2'b00, 0)); // 8 data word
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h15A, 0, 0, 8'h00, 2'b00, 0)); // 9
      vecs.push_back(mk(1, 0, 10'h000, 1, 0, 8'h10, 8'h00, 0, 8'h00, 0, 10'h15A, 1, 0, 8'h00, 2'b00, 0)); // 10 host read gnt
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h210, 0, 0, 8'h00, 2'b00, 0)); // 11
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 8'h77, 1, 10'h300, 0, 0, 8'h00, 2'b00, 0)); // 12 H_WAIT hides tx
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 8'h5A, 0, 10'h300, 0, 1, 8'h5A, 2'b00, 1)); // 13 host rdata
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h300, 0, 0, 8'h5A, 2'b00, 0)); // 14
      vecs.push_back(mk(1, 1, 10'h005, 1, 1, 8'h20, 8'h33, 0, 8'h00, 1, 10'h005, 0, 0, 8'h5A, 2'b00, 0)); // 15 spi beats host
      vecs.push_back(mk(1, 0, 10'h000, 1, 1, 8'h20, 8'h33, 0, 8'h00, 0, 10'h005, 0, 0, 8'h5A, 2'b00, 0)); // 16 withheld
      vecs.push_back(mk(1, 1, 10'h1AB, 1, 1, 8'h20, 8'h33, 0, 8'h00, 1, 10'h1AB, 0, 0, 8'h5A, 2'b00, 0)); // 17 spi ends
      vecs.push_back(mk(1, 0, 10'h000, 1, 1, 8'h20, 8'h33, 0, 8'h00, 0, 10'h1AB, 1, 0, 8'h5A, 2'b00, 0)); // 18 now granted
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h020, 0, 0, 8'h5A, 2'b00, 0)); // 19
      vecs.push_back(mk(1, 1, 10'h0C4, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h133, 0, 0, 8'h5A, 2'b00, 0)); // 20 spi buffered
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h0C4, 0, 0, 8'h5A, 2'b00, 0)); // 21 buffer out
      vecs.push_back(mk(1, 1, 10'h1EE, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h1EE, 0, 0, 8'h5A, 2'b00, 0)); // 22
      vecs.push_back(mk(1, 0, 10'h000, 1, 0, 8'h44, 8'h00, 0, 8'h00, 0, 10'h1EE, 1, 0, 8'h5A, 2'b00, 0)); // 23 host read gnt
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h244, 0, 0, 8'h5A, 2'b00, 0)); // 24
      vecs.push_back(mk(1, 1, 10'h2C8, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h300, 0, 0, 8'h5A, 2'b00, 0)); // 25 buffered
      vecs.push_back(mk(1, 1, 10'h0FF, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 10'h300, 0, 0, 8'h5A, 2'b01, 0)); // 26 dropped
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 8'h9C, 0, 10'h300, 0, 1, 8'h9C, 2'b01, 1)); // 27 host rdata
      vecs.push_back(mk(1, 1, 10'h1D0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h2C8, 0, 0, 8'h9C, 2'b01, 0)); // 28 drain+refill
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h1D0, 0, 0, 8'h9C, 2'b01, 0)); // 29
      vecs.push_back(mk(1, 1, 10'h300, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h300, 0, 0, 8'h9C, 2'b01, 0)); // 30 cmd11 pass
      vecs.push_back(mk(1, 0, 10'h000, 1, 1, 8'h01, 8'h02, 0, 8'h00, 0, 10'h300, 1, 0, 8'h9C, 2'b01, 0)); // 31 still IDLE
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h001, 0, 0, 8'h9C, 2'b01, 0)); // 32
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h102, 0, 0, 8'h9C, 2'b01, 0)); // 33
      vecs.push_back(mk(1, 1, 10'h211, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h211, 0, 0, 8'h9C, 2'b01, 0)); // 34 spi raddr
      vecs.push_back(mk(1, 1, 10'h300, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h300, 0, 0, 8'h9C, 2'b01, 0)); // 35 spi rdata
      vecs.push_back(mk(1, 0, 10'h000, 1, 1, 8'h03, 8'h04, 0, 8'h00, 0, 10'h300, 0, 0, 8'h9C, 2'b01, 0)); // 36 waiting
      vecs.push_back(mk(1, 0, 10'h000, 1, 1, 8'h03, 8'h04, 1, 8'hA5, 0, 10'h300, 0, 0, 8'h9C, 2'b01, 1)); // 37 ram answers
      vecs.push_back(mk(1, 0, 10'h000, 1, 1, 8'h03, 8'h04, 0, 8'h00, 0, 10'h300, 1, 0, 8'h9C, 2'b01, 0)); // 38 granted
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h003, 0, 0, 8'h9C, 2'b01, 0)); // 39
      vecs.push_back(mk(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 10'h104, 0, 0, 8'h9C, 2'b01, 0)); // 40

      idle();
      rst_n = 1'b0;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].sv, vecs[i].sd, vecs[i].hr, vecs[i].hw,
               vecs[i].ha, vecs[i].hd, vecs[i].tv, vecs[i].dq);
         tick();
         check($sformatf("row%0d ram_rx_valid", i), 32'(ram_rx_valid), 32'(vecs[i].e_rv));
         check($sformatf("row%0d ram_din", i),      32'(ram_din),      32'(vecs[i].e_din));
         check($sformatf("row%0d host_gnt", i),     32'(host_gnt),     32'(vecs[i].e_gnt));
         check($sformatf("row%0d host_rvalid", i),  32'(host_rvalid),  32'(vecs[i].e_rvld));
         check($sformatf("row%0d host_rdata", i),   32'(host_rdata),   32'(vecs[i].e_rdata));
         check($sformatf("row%0d err", i),          32'(err),          32'(vecs[i].e_err));
         check($sformatf("row%0d spi_tx_valid", i), 32'(spi_tx_valid), 32'(vecs[i].e_stxv));
      end

      // ---- host read with no RAM answer: timeout after 8 cycles in H_WAIT ----
      drive(1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 8'h00);
      tick();
      check("tmo gnt", 32'(host_gnt), 32'd1);
      idle();
      tick();
      check("tmo addr word", 32'(ram_din), 32'h255);
      tick();
      check("tmo data word", 32'(ram_din), 32'h300);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check($sformatf("tmo cycle%0d err", i), 32'(err), (i == 8) ? 32'd3 : 32'd1);
         check($sformatf("tmo cycle%0d host_rvalid", i), 32'(host_rvalid), 32'd0);
      end
      check("tmo host_rdata kept", 32'(host_rdata), 32'h9C);
      drive(1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 8'h66, 8'h77, 1'b0, 8'h00);
      tick();
      check("post-tmo gnt", 32'(host_gnt), 32'd1);
      idle();
      tick();
      check("post-tmo addr word", 32'(ram_din), 32'h066);
      tick();
      check("post-tmo data word", 32'(ram_din), 32'h177);
      check("post-tmo err sticky", 32'(err), 32'd3);

      // ---- reset during an in-flight host write aborts it ----
      drive(1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 8'h88, 8'h99, 1'b0, 8'h00);
      tick();
      check("abort gnt", 32'(host_gnt), 32'd1);
      idle();
      rst_n = 1'b0;
      tick();
      check("abort ram_rx_valid", 32'(ram_rx_valid), 32'd0);
      check("abort ram_din", 32'(ram_din), 32'h000);
      check("abort err", 32'(err), 32'd0);
      check("abort host_rdata", 32'(host_rdata), 32'h00);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("abort quiet%0d", i), 32'(ram_rx_valid), 32'd0);
      end
      drive(1'b1, 1'b1, 10'h1AB, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      check("after reset spi valid", 32'(ram_rx_valid), 32'd1);
      check("after reset spi word", 32'(ram_din), 32'h1AB);
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
